spi_master: RTL and testbench

Single-clock SPI controller that initiates write and read transactions on the team's 4-wire SPI memory link. It serializes a command bit, address and write data onto `o_mosi` under `o_cs`, and collects read data from `i_miso`. It completes on the responder's `i_ready` and `i_op_done` handshake strobes, with a timeout guard. The block sits between a host-side register or command interface and the SPI memory responder, and both run on the same `clk`.

---
 rtl/spi_master.sv | 155 +++++++++++++++
 tb/tb_spi_master.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: SPI controller for the memory link; shifts out op/addr/data, collects read data, guards waits with a timeout.
module spi_master #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_newd,
    input  logic       i_op,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_din,
    input  logic       i_miso,
    input  logic       i_ready,
    input  logic       i_op_done,
    output logic       o_cs,
    output logic       o_mosi,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [7:0] o_dout
);
    typedef enum logic [2:0] {IDLE, CMD, TX, WAIT_READY, RX, WAIT_DONE} state_t;
    state_t state_q, state_d;
    logic op_q, op_d;
    logic [7:0] addr_q, addr_d, din_q, din_d, rx_q, rx_d, dout_q, dout_d, wait_q, wait_d;
    logic [4:0] bit_q, bit_d;
    logic cs_q, cs_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [15:0] payload;
    logic [4:0] last;
    logic expired;
    assign payload = {din_q, addr_q};
    assign last = op_q ? 5'd16 : 5'd8;
    assign expired = wait_q == 8'(TIMEOUT - 1);
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        addr_d = addr_q;
        din_d = din_q;
        rx_d = rx_q;
        dout_d = dout_q;
        wait_d = wait_q;
        bit_d = bit_q;
        cs_d = cs_q;
        mosi_d = mosi_q;
        busy_d = busy_q;
        done_d = 1'b0;
        err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cs_d = 1'b1;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (i_newd) begin
                    op_d = i_op;
                    addr_d = i_addr;
                    din_d = i_din;
                    cs_d = 1'b0;
                    mosi_d = i_op;
                    busy_d = 1'b1;
                    state_d = CMD;
                end
            end
            CMD: begin
                bit_d = '0;
                state_d = TX;
            end
            TX: begin
                if (bit_q == last) begin
                    cs_d = 1'b1;
                    mosi_d = 1'b0;
                    wait_d = '0;
                    state_d = op_q ? WAIT_DONE : WAIT_READY;
                end else begin
                    mosi_d = payload[bit_q[3:0]];
                    bit_d = bit_q + 5'd1;
                end
            end
            WAIT_READY: begin
                if (i_ready) begin
                    bit_d = '0;
                    state_d = RX;
                end else if (expired) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    err_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RX: begin
                rx_d[bit_q[2:0]] = i_miso;
                if (bit_q == 5'd7) begin
                    wait_d = '0;
                    state_d = WAIT_DONE;
                end else begin
                    bit_d = bit_q + 5'd1;
                end
            end
            WAIT_DONE: begin
                // a strobe on the final allowed cycle still wins over the timeout
                if (i_op_done) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    dout_d = op_q ? dout_q : rx_q;
                    state_d = IDLE;
                end else if (expired) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    err_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q <= 1'b0;
            addr_q <= '0;
            din_q <= '0;
            rx_q <= '0;
            dout_q <= '0;
            wait_q <= '0;
            bit_q <= '0;
            cs_q <= 1'b1;
            mosi_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            addr_q <= addr_d;
            din_q <= din_d;
            rx_q <= rx_d;
            dout_q <= dout_d;
            wait_q <= wait_d;
            bit_q <= bit_d;
            cs_q <= cs_d;
            mosi_q <= mosi_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end
    assign o_cs = cs_q;
    assign o_mosi = mosi_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_err = err_q;
    assign o_dout = dout_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized frames against a timing-offset model of the SPI link, plus literal checks of the directed cases.
module tb_spi_master;
    localparam int TO = 16;
    logic clk, rst_n, i_newd, i_op, i_miso, i_ready, i_op_done;
    logic [7:0] i_addr, i_din;
    logic o_cs, o_mosi, o_busy, o_done, o_err;
    logic [7:0] o_dout;
    spi_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_newd(i_newd), .i_op(i_op), .i_addr(i_addr), .i_din(i_din),
        .i_miso(i_miso), .i_ready(i_ready), .i_op_done(i_op_done), .o_cs(o_cs), .o_mosi(o_mosi),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_dout(o_dout)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int errors = 0, checks = 0, cyc = 0;
    logic [12:0] exp_a [int];
    logic [7:0] mem [256];
    bit have = 0, c_op, m_err;
    int e0, fin, w0, rx0, wd0, c_r, c_d, nx_r, nx_d;
    logic [7:0] c_addr, c_din, c_data, dout_m = 8'h00;
    int l_e0, l_done, l_ndone;
    logic [17:0] l_seq;
    logic [31:0] l_cs;
    logic l_err, l_csd;
    logic [7:0] l_dout;
    always @(negedge clk) begin
        if (exp_a.exists(cyc)) begin
            checks++;
            if ({o_cs, o_mosi, o_busy, o_done, o_err, o_dout} !== exp_a[cyc]) begin
                errors++;
                $display("FAIL cycle %0d {cs,mosi,busy,done,err,dout}: got %b_%b_%b_%b_%b_%h want %b_%h", cyc,
                         o_cs, o_mosi, o_busy, o_done, o_err, o_dout, exp_a[cyc][12:8], exp_a[cyc][7:0]);
            end
            exp_a.delete(cyc);
        end
    end
    task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask
    // frame schedule as offsets from the acceptance edge
    task automatic plan();
        w0 = c_op ? 18 : 10;
        rx0 = -1;
        wd0 = -1;
        if (c_op) wd0 = w0;
        else if (c_r >= 1 && c_r <= TO) begin
            rx0 = w0 + c_r;
            wd0 = rx0 + 8;
        end
        if (wd0 < 0) begin
            fin = w0 + TO;
            m_err = 1;
        end else if (c_d >= 1 && c_d <= TO) begin
            fin = wd0 + c_d;
            m_err = 0;
        end else begin
            fin = wd0 + TO;
            m_err = 1;
        end
    endtask
    task automatic tick(input bit newd, input bit op, input logic [7:0] a, input logic [7:0] dn, input bit rst);
        int n, j;
        logic [15:0] pay;
        bit rdy, opd, mi;
        n = cyc + 1;
        if (rst) begin
            have = 0;
            dout_m = 8'h00;
        end else if (newd && (!have || n - e0 > fin)) begin
            have = 1;
            e0 = n;
            c_op = op;
            c_addr = a;
            c_din = dn;
            c_r = nx_r;
            c_d = nx_d;
            c_data = mem[a];
            plan();
        end
        j = n - e0;
        rdy = $urandom_range(0, 3) == 0;
        opd = $urandom_range(0, 3) == 0;
        mi = 1'($urandom_range(0, 1));
        if (have) begin
            if (!c_op && j > w0 && j <= w0 + TO) rdy = (j == w0 + c_r);
            if (wd0 >= 0 && j > wd0 && j <= wd0 + TO) opd = (j == wd0 + c_d);
            if (rx0 >= 0 && j > rx0 && j <= rx0 + 8) mi = c_data[j-rx0-1];
            if (j == fin && !m_err) begin
                if (c_op) mem[c_addr] = c_din;
                else dout_m = c_data;
            end
            pay = {c_din, c_addr};
            exp_a[n] = {j >= w0 ? 1'b1 : 1'b0, j < 2 ? c_op : (j < w0 ? pay[j-2] : 1'b0),
                        j < fin, j == fin, j == fin && m_err, dout_m};
        end else begin
            exp_a[n] = {5'b10000, dout_m};
        end
        rst_n = !rst;
        i_newd = newd;
        i_op = op;
        i_addr = a;
        i_din = dn;
        i_ready = rdy;
        i_op_done = opd;
        i_miso = mi;
        @(posedge clk);
        cyc = n;
        #1;
    endtask
    task automatic rnd_tick(input bit newd);
        tick(newd, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b0);
    endtask
    task automatic rec();
        int jj;
        jj = cyc - l_e0;
        if (jj < 18) l_seq = {l_seq[16:0], o_mosi};
        if (jj < 32) l_cs[jj] = o_cs;
        if (o_done) begin
            l_ndone++;
            if (l_done < 0) begin
                l_done = jj;
                l_err = o_err;
                l_dout = o_dout;
                l_csd = o_cs;
            end
        end
    endtask
    // mode: 0 random noise, 1 newd held, 2 newd pulse at E5, 3 quiet
    task automatic do_txn(input bit op, input logic [7:0] a, input logic [7:0] dn, input int r, input int d,
                          input int gap, input int mode);
        int j;
        nx_r = r;
        nx_d = d;
        tick(1'b1, op, a, dn, 1'b0);
        l_e0 = cyc;
        l_done = -1;
        l_ndone = 0;
        l_seq = '0;
        l_cs = '0;
        rec();
        while (cyc - e0 < fin) begin
            j = cyc + 1 - l_e0;
            if (mode == 1) tick(1'b1, op, a, dn, 1'b0);
            else if (mode == 2) tick(j == 5, ~op, 8'($urandom), 8'($urandom), 1'b0);
            else if (mode == 3) tick(1'b0, op, a, dn, 1'b0);
            else rnd_tick($urandom_range(0, 7) == 0);
            rec();
        end
        repeat (gap) begin
            rnd_tick(1'b0);
            rec();
        end
    endtask
    function automatic int pick();
        int k;
        k = $urandom_range(0, 15);
        return k == 0 ? 0 : k == 1 ? TO : k == 2 ? TO + 1 : $urandom_range(1, 3);
    endfunction
    initial begin
        int e0a;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        pin("reset_outputs", {o_cs, o_mosi, o_busy, o_done, o_err, o_dout}, 13'h1000);
        tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        do_txn(1'b1, 8'h05, 8'hA5, 0, 2, 2, 3);
        pin("wr_mosi", l_seq, 18'b111010000010100101);
        pin("wr_cs_rise", {l_cs[17], l_cs[18]}, 2'b01);
        pin("wr_latency", l_done, 20);
        pin("wr_err", l_err, 0);
        do_txn(1'b0, 8'h05, 8'h00, 2, 1, 2, 3);
        pin("rd_mosi", l_seq, 18'b001010000000000000);
        pin("rd_cs_rise", {l_cs[9], l_cs[10]}, 2'b01);
        pin("rd_latency", l_done, 21);
        pin("rd_dout", l_dout, 8'hA5);
        do_txn(1'b1, 8'h1F, 8'h3C, 0, 1, 0, 1);
        e0a = l_e0;
        do_txn(1'b0, 8'h1F, 8'h00, 2, 1, 2, 3);
        pin("b2b_start", l_e0 - e0a, 20);
        pin("b2b_dout", l_dout, 8'h3C);
        do_txn(1'b0, 8'h77, 8'h00, 0, 1, 2, 3);
        pin("to_latency", l_done, 26);
        pin("to_err_cs_dout", {l_err, l_csd, l_dout}, {1'b1, 1'b1, 8'h3C});
        do_txn(1'b1, 8'h22, 8'h99, 0, 2, 4, 2);
        pin("newd_busy_ndone", l_ndone, 1);
        pin("newd_busy_latency", l_done, 20);
        nx_r = 2;
        nx_d = 1;
        tick(1'b1, 1'b0, 8'h42, 8'h00, 1'b0);
        repeat (7) tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        pin("rst_mid", {o_cs, o_busy, o_done, o_dout}, {1'b1, 1'b0, 1'b0, 8'h00});
        tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        do_txn(1'b1, 8'h10, 8'h5A, 0, 2, 1, 3);
        pin("post_rst_wr", {l_done, l_err}, {31'd20, 1'b0});
        repeat (200)
            do_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom), pick(), pick(),
                   $urandom_range(0, 3), 0);
        repeat (3) rnd_tick(1'b0);
        #10;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
